// File: rtl/mem_copy_engine.sv
// Bus-master copy/fill engine for a 256 x 64 single-port memory.
// Copies word ranges (read then write, ascending) or fills a range with a pattern, keeping a checksum.
module mem_copy_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [7:0]  src,
    input  logic [7:0]  dst,
    input  logic [8:0]  len,
    input  logic [63:0] pattern,
    input  logic [63:0] mem_dataout,
    output logic [63:0] mem_adr,
    output logic [63:0] mem_datain,
    output logic        mem_w,
    output logic        mem_r,
    output logic        busy,
    output logic        done,
    output logic [63:0] checksum
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic        mode_q;
    logic [7:0]  src_q, dst_q;
    logic [8:0]  len_q, idx_q;
    logic [63:0] pattern_q, buffer_q, checksum_q;

    logic [8:0]  len_sat;
    logic [8:0]  idx_inc;
    logic        last;

    // Word counts above the memory depth saturate so every word is touched once.
    assign len_sat  = (len > 9'd256) ? 9'd256 : len;
    assign idx_inc  = idx_q + 9'd1;
    assign last     = (idx_inc == len_q);
    assign checksum = checksum_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_sat == 9'd0) state_d = DONE;
                    else if (mode)       state_d = WRITE;
                    else                 state_d = READ;
                end
            end
            READ:    state_d = WRITE;
            WRITE: begin
                if (last)        state_d = DONE;
                else if (mode_q) state_d = WRITE;
                else             state_d = READ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs depend only on registered state, never on start.
    always_comb begin
        mem_adr    = 64'd0;
        mem_datain = 64'd0;
        mem_w      = 1'b0;
        mem_r      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            READ: begin
                mem_r   = 1'b1;
                mem_adr = {56'd0, src_q + idx_q[7:0]};
                busy    = 1'b1;
            end
            WRITE: begin
                mem_w      = 1'b1;
                mem_adr    = {56'd0, dst_q + idx_q[7:0]};
                mem_datain = mode_q ? pattern_q : buffer_q;
                busy       = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            src_q      <= 8'd0;
            dst_q      <= 8'd0;
            len_q      <= 9'd0;
            idx_q      <= 9'd0;
            pattern_q  <= 64'd0;
            buffer_q   <= 64'd0;
            checksum_q <= 64'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        src_q      <= src;
                        dst_q      <= dst;
                        len_q      <= len_sat;
                        pattern_q  <= pattern;
                        idx_q      <= 9'd0;
                        checksum_q <= 64'd0;
                    end
                end
                READ:  buffer_q <= mem_dataout;
                WRITE: begin
                    checksum_q <= checksum_q + mem_datain;
                    idx_q      <= idx_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural 256 x 64 memory.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  src = 8'd0;
  logic [7:0]  dst = 8'd0;
  logic [8:0]  len = 9'd0;
  logic [63:0] pattern = 64'd0;
  logic [63:0] mem_dataout;
  logic [63:0] mem_adr;
  logic [63:0] mem_datain;
  logic        mem_w;
  logic        mem_r;
  logic        busy;
  logic        done;
  logic [63:0] checksum;

  logic [63:0] mem [256];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_wa = 8'd0;
  logic [63:0] tb_wd = 64'd0;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int adr_hi_err = 0;
  int both_err = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int lat;

  localparam logic [63:0] PAT = 64'hA5A5_0000_FFFF_1234;

  // clock / reset block
  always #5 clk = ~clk;

  mem_copy_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .pattern(pattern), .mem_dataout(mem_dataout), .mem_adr(mem_adr),
    .mem_datain(mem_datain), .mem_w(mem_w), .mem_r(mem_r), .busy(busy),
    .done(done), .checksum(checksum)
  );

  // memory model: read data valid in the same cycle as mem_r
  assign mem_dataout = mem_r ? mem[mem_adr[7:0]] : 64'd0;
  always @(posedge clk) begin
    if (mem_w) mem[mem_adr[7:0]] <= mem_datain;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end

  // bus monitor
  always @(negedge clk) begin
    if (mem_adr[63:8] != 56'd0) adr_hi_err++;
    if (mem_w && mem_r) both_err++;
    if (mem_w || mem_r) acc_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tb_write(input logic [7:0] a, input logic [63:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic issue(input logic m, input logic [7:0] s, input logic [7:0] d,
                       input logic [8:0] l, input logic [63:0] p);
    @(negedge clk);
    start = 1'b1;
    mode = m;
    src = s;
    dst = d;
    len = l;
    pattern = p;
  endtask

  // Counts negedges from the accepting edge until done; optionally keeps hammering start.
  task automatic wait_done(input logic keep, output int c);
    c = 0;
    forever begin
      @(negedge clk);
      c++;
      if (done || c >= 400) begin
        start = 1'b0;
        break;
      end
      if (keep) begin
        start = 1'b1;
        mode = 1'b1;
        src = 8'($urandom_range(0, 255));
        dst = 8'($urandom_range(0, 255));
        len = 9'($urandom_range(1, 300));
        pattern = {$urandom, $urandom};
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mem_w", {63'd0, mem_w}, 64'd0);
    check("rst_mem_r", {63'd0, mem_r}, 64'd0);
    check("rst_adr", mem_adr, 64'd0);
    check("rst_datain", mem_datain, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_checksum", checksum, 64'd0);

    // copy 10..13 -> 100..103
    for (int i = 0; i < 4; i++) tb_write(8'(10 + i), 64'(i + 1));
    issue(1'b0, 8'd10, 8'd100, 9'd4, 64'd0);
    wait_done(1'b0, lat);
    check("copy_latency", 64'(lat), 64'd9);
    check("copy_checksum", checksum, 64'd10);
    for (int i = 0; i < 4; i++) check("copy_dst", mem[100 + i], 64'(i + 1));
    check("copy_src10", mem[10], 64'd1);
    check("copy_src13", mem[13], 64'd4);

    // fill with wrap
    issue(1'b1, 8'd0, 8'd254, 9'd4, PAT);
    wait_done(1'b0, lat);
    check("fill_latency", 64'(lat), 64'd5);
    check("fill_checksum", checksum, 64'h9694_0003_FFFC_48D0);
    check("fill_254", mem[254], PAT);
    check("fill_255", mem[255], PAT);
    check("fill_0", mem[0], PAT);
    check("fill_1", mem[1], PAT);

    // len = 0
    @(negedge clk);
    acc_cnt = 0;
    issue(1'b0, 8'd10, 8'd120, 9'd0, 64'd0);
    wait_done(1'b0, lat);
    check("len0_latency", 64'(lat), 64'd1);
    check("len0_accesses", 64'(acc_cnt), 64'd0);
    check("len0_checksum", checksum, 64'd0);

    // overlapping copy
    tb_write(8'd20, 64'd7);
    tb_write(8'd21, 64'd8);
    issue(1'b0, 8'd20, 8'd21, 9'd2, 64'd0);
    wait_done(1'b0, lat);
    check("ovl_latency", 64'(lat), 64'd5);
    check("ovl_21", mem[21], 64'd7);
    check("ovl_22", mem[22], 64'd7);
    check("ovl_checksum", checksum, 64'd14);

    // start hammered while busy, including during the done cycle
    for (int i = 0; i < 8; i++) tb_write(8'(30 + i), 64'(3 * i + 5));
    @(negedge clk);
    done_cnt = 0;
    issue(1'b0, 8'd30, 8'd130, 9'd8, 64'd0);
    wait_done(1'b1, lat);
    repeat (4) @(negedge clk);
    check("robust_latency", 64'(lat), 64'd17);
    check("robust_done_pulses", 64'(done_cnt), 64'd1);
    check("robust_checksum", checksum, 64'd124);
    check("robust_idle_busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 8; i++) check("robust_dst", mem[130 + i], 64'(3 * i + 5));

    // len > 256 saturates
    issue(1'b1, 8'd0, 8'd0, 9'd300, 64'd1);
    wait_done(1'b0, lat);
    check("sat_latency", 64'(lat), 64'd257);
    check("sat_checksum", checksum, 64'd256);

    // reset during the 3rd write of a 10-word fill
    for (int i = 0; i < 10; i++) tb_write(8'(50 + i), 64'd0);
    issue(1'b1, 8'd0, 8'd50, 9'd10, 64'hDEAD_BEEF_0000_0001);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_mem_w", {63'd0, mem_w}, 64'd0);
    check("mrst_mem_r", {63'd0, mem_r}, 64'd0);
    check("mrst_adr", mem_adr, 64'd0);
    check("mrst_datain", mem_datain, 64'd0);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_done", {63'd0, done}, 64'd0);
    check("mrst_checksum", checksum, 64'd0);
    rst = 1'b0;
    check("mrst_50", mem[50], 64'hDEAD_BEEF_0000_0001);
    check("mrst_51", mem[51], 64'hDEAD_BEEF_0000_0001);
    check("mrst_53", mem[53], 64'd0);
    check("mrst_59", mem[59], 64'd0);

    // normal command after reset
    issue(1'b1, 8'd0, 8'd200, 9'd2, 64'd5);
    wait_done(1'b0, lat);
    check("post_latency", 64'(lat), 64'd3);
    check("post_checksum", checksum, 64'd10);
    check("post_200", mem[200], 64'd5);
    check("post_201", mem[201], 64'd5);

    check("adr_high_bits", 64'(adr_hi_err), 64'd0);
    check("rw_exclusive", 64'(both_err), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
